// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes and register IDs.
// Used by the fetch, decode/write-back and execute stages.
package y86_pkg;

  typedef logic [3:0] reg_id_t;

  typedef enum logic [3:0] {
    I_HALT  = 4'h0,
    I_NOP   = 4'h1,
    I_RRMOV = 4'h2,
    I_IRMOV = 4'h3,
    I_RMMOV = 4'h4,
    I_MRMOV = 4'h5,
    I_OP    = 4'h6,
    I_JXX   = 4'h7,
    I_CALL  = 4'h8,
    I_RET   = 4'h9,
    I_PUSH  = 4'hA,
    I_POP   = 4'hB
  } icode_e;

  localparam reg_id_t REG_RSP  = 4'h4;
  localparam reg_id_t REG_NONE = 4'hF;
  localparam int      NUM_REGS = 15;

endpackage

// File: rtl/decode_writeback_if.sv
// Bus between fetch/execute (master) and the decode/write-back stage (slave).
interface decode_writeback_if;
  import y86_pkg::*;

  logic [3:0]  icode;
  reg_id_t     rA;
  reg_id_t     rB;
  logic        cnd;
  logic [63:0] valE;
  logic [63:0] valM;
  logic        wb_en;
  logic        stat_halt;
  reg_id_t     srcA;
  reg_id_t     srcB;
  reg_id_t     dstE;
  reg_id_t     dstM;
  logic [63:0] valA;
  logic [63:0] valB;
  logic        halted;

  modport master (
    output icode, rA, rB, cnd, valE, valM, wb_en, stat_halt,
    input  srcA, srcB, dstE, dstM, valA, valB, halted
  );

  modport slave (
    input  icode, rA, rB, cnd, valE, valM, wb_en, stat_halt,
    output srcA, srcB, dstE, dstM, valA, valB, halted
  );

endinterface

// File: rtl/y86_regfile.sv
// 15x64 architectural register file: two combinational read ports, two write
// ports with M priority. Define WB_BYPASS_EN for write-through reads.
module y86_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'd1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        we_i,
  input  reg_id_t     dst_e_i,
  input  reg_id_t     dst_m_i,
  input  logic [63:0] val_e_i,
  input  logic [63:0] val_m_i,
  input  reg_id_t     src_a_i,
  input  reg_id_t     src_b_i,
  output logic [63:0] val_a_o,
  output logic [63:0] val_b_o
);

  logic [63:0] regs_q [NUM_REGS];
  logic [63:0] regs_d [NUM_REGS];

  function automatic logic [63:0] read_port(input reg_id_t src);
    logic [63:0] data;
    data = (src == REG_NONE) ? 64'd0 : regs_q[src];
`ifdef WB_BYPASS_EN
    if (we_i && src != REG_NONE) begin
      if (src == dst_m_i)      data = val_m_i;
      else if (src == dst_e_i) data = val_e_i;
    end
`endif
    return data;
  endfunction

  // M is applied after E so popq %rsp keeps the loaded value.
  always_comb begin
    regs_d = regs_q;
    if (we_i) begin
      if (dst_e_i != REG_NONE) regs_d[dst_e_i] = val_e_i;
      if (dst_m_i != REG_NONE) regs_d[dst_m_i] = val_m_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs_q[i] <= (i == int'(REG_RSP)) ? RSP_INIT : 64'd0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign val_a_o = read_port(src_a_i);
  assign val_b_o = read_port(src_b_i);

endmodule

// File: rtl/decode_writeback.sv
// SEQ Y86-64 decode/write-back stage: register ID decode, sticky halt flag,
// and the register file. WB_BYPASS_EN enables write-through reads.
module decode_writeback
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_INIT = 64'd1024
) (
  input logic              clk,
  input logic              rst,
  decode_writeback_if.slave bus
);

  reg_id_t src_a, src_b, dst_e, dst_m;
  logic    halted_q, halted_d;
  logic    we;

  always_comb begin
    src_a = REG_NONE;
    src_b = REG_NONE;
    dst_e = REG_NONE;
    dst_m = REG_NONE;
    case (bus.icode)
      I_RRMOV: begin
        src_a = bus.rA;
        if (bus.cnd) dst_e = bus.rB;
      end
      I_IRMOV: dst_e = bus.rB;
      I_RMMOV: begin
        src_a = bus.rA;
        src_b = bus.rB;
      end
      I_MRMOV: begin
        src_b = bus.rB;
        dst_m = bus.rA;
      end
      I_OP: begin
        src_a = bus.rA;
        src_b = bus.rB;
        dst_e = bus.rB;
      end
      I_CALL: begin
        src_b = REG_RSP;
        dst_e = REG_RSP;
      end
      I_RET: begin
        src_a = REG_RSP;
        src_b = REG_RSP;
        dst_e = REG_RSP;
      end
      I_PUSH: begin
        src_a = bus.rA;
        src_b = REG_RSP;
        dst_e = REG_RSP;
      end
      I_POP: begin
        src_a = REG_RSP;
        src_b = REG_RSP;
        dst_e = REG_RSP;
        dst_m = bus.rA;
      end
      default: ;
    endcase
  end

  // The halting instruction still commits; only later commits are blocked.
  assign we       = bus.wb_en && !halted_q;
  assign halted_d = halted_q || (bus.wb_en && bus.stat_halt);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end

  y86_regfile #(.RSP_INIT(RSP_INIT)) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we_i    (we),
    .dst_e_i (dst_e),
    .dst_m_i (dst_m),
    .val_e_i (bus.valE),
    .val_m_i (bus.valM),
    .src_a_i (src_a),
    .src_b_i (src_b),
    .val_a_o (bus.valA),
    .val_b_o (bus.valB)
  );

  assign bus.srcA   = src_a;
  assign bus.srcB   = src_b;
  assign bus.dstE   = dst_e;
  assign bus.dstM   = dst_m;
  assign bus.halted = halted_q;

endmodule

// File: tb/tb_decode_writeback.sv
// Directed, table-driven bench for decode_writeback, plus hand sequences for
// halt, reset and same-cycle read/write behaviour (with or without WB_BYPASS_EN).
module tb_decode_writeback;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  decode_writeback_if bus();

  decode_writeback #(.RSP_INIT(64'd1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  rA;
    logic [3:0]  rB;
    logic        cnd;
    logic [63:0] valE;
    logic [63:0] valM;
    logic        wbEn;
    logic [3:0]  expSrcA;
    logic [3:0]  expSrcB;
    logic [3:0]  expDstE;
    logic [3:0]  expDstM;
    logic [63:0] expValA;
    logic [63:0] expValB;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // Drives the instruction fields with wb_en low so reads never see a bypass.
  task automatic applyStimulus(input logic [3:0] icode, input logic [3:0] rA, input logic [3:0] rB,
                               input logic cnd, input logic [63:0] valE, input logic [63:0] valM);
    @(negedge clk);
    bus.icode     = icode;
    bus.rA        = rA;
    bus.rB        = rB;
    bus.cnd       = cnd;
    bus.valE      = valE;
    bus.valM      = valM;
    bus.wb_en     = 1'b0;
    bus.stat_halt = 1'b0;
    #1;
  endtask

  task automatic commit(input logic wbEn, input logic statHalt);
    bus.wb_en     = wbEn;
    bus.stat_halt = statHalt;
    @(posedge clk);
    #1;
    bus.wb_en     = 1'b0;
    bus.stat_halt = 1'b0;
  endtask

  task automatic checkOutput(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    check({tag, ".srcA"},   64'(bus.srcA),   64'(v.expSrcA));
    check({tag, ".srcB"},   64'(bus.srcB),   64'(v.expSrcB));
    check({tag, ".dstE"},   64'(bus.dstE),   64'(v.expDstE));
    check({tag, ".dstM"},   64'(bus.dstM),   64'(v.expDstM));
    check({tag, ".valA"},   bus.valA,        v.expValA);
    check({tag, ".valB"},   bus.valB,        v.expValB);
    check({tag, ".halted"}, 64'(bus.halted), 64'd0);
  endtask

  initial begin
    // icode rA rB cnd valE valM wb | srcA srcB dstE dstM valA valB
    vecs[0]  = '{4'h1, 4'hF, 4'hF, 1'b0, 64'h11,   64'h0,   1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0};
    vecs[1]  = '{4'h3, 4'hF, 4'h2, 1'b0, 64'h55,   64'h0,   1'b1, 4'hF, 4'hF, 4'h2, 4'hF, 64'h0,   64'h0};
    vecs[2]  = '{4'h6, 4'h2, 4'h4, 1'b0, 64'h0,    64'h0,   1'b0, 4'h2, 4'h4, 4'h4, 4'hF, 64'h55,  64'd1024};
    vecs[3]  = '{4'h2, 4'h1, 4'h3, 1'b0, 64'h99,   64'h0,   1'b1, 4'h1, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0};
    vecs[4]  = '{4'h6, 4'h3, 4'h2, 1'b0, 64'h0,    64'h0,   1'b0, 4'h3, 4'h2, 4'h2, 4'hF, 64'h0,   64'h55};
    vecs[5]  = '{4'h2, 4'h1, 4'h3, 1'b1, 64'h99,   64'h0,   1'b1, 4'h1, 4'hF, 4'h3, 4'hF, 64'h0,   64'h0};
    vecs[6]  = '{4'h4, 4'h3, 4'h2, 1'b0, 64'h0,    64'h0,   1'b0, 4'h3, 4'h2, 4'hF, 4'hF, 64'h99,  64'h55};
    vecs[7]  = '{4'hB, 4'h4, 4'hF, 1'b0, 64'h408,  64'h77,  1'b1, 4'h4, 4'h4, 4'h4, 4'h4, 64'd1024, 64'd1024};
    vecs[8]  = '{4'hA, 4'h2, 4'hF, 1'b0, 64'h0,    64'h0,   1'b0, 4'h2, 4'h4, 4'h4, 4'hF, 64'h55,  64'h77};
    vecs[9]  = '{4'h5, 4'h6, 4'h3, 1'b0, 64'h200,  64'h123, 1'b1, 4'hF, 4'h3, 4'hF, 4'h6, 64'h0,   64'h99};
    vecs[10] = '{4'h8, 4'hF, 4'hF, 1'b0, 64'h70,   64'h0,   1'b1, 4'hF, 4'h4, 4'h4, 4'hF, 64'h0,   64'h77};
    vecs[11] = '{4'h9, 4'hF, 4'hF, 1'b0, 64'h0,    64'h0,   1'b0, 4'h4, 4'h4, 4'h4, 4'hF, 64'h70,  64'h70};
    vecs[12] = '{4'h7, 4'h6, 4'h6, 1'b0, 64'h0,    64'h0,   1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0};
    vecs[13] = '{4'hC, 4'h6, 4'h6, 1'b0, 64'hDEAD, 64'hBEEF, 1'b1, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,  64'h0};
    vecs[14] = '{4'h6, 4'h6, 4'hE, 1'b0, 64'h0,    64'h0,   1'b0, 4'h6, 4'hE, 4'hE, 4'hF, 64'h123, 64'h0};
    vecs[15] = '{4'h0, 4'h6, 4'h6, 1'b0, 64'h0,    64'h0,   1'b0, 4'hF, 4'hF, 4'hF, 4'hF, 64'h0,   64'h0};

    bus.icode = 4'h1; bus.rA = 4'hF; bus.rB = 4'hF; bus.cnd = 1'b0;
    bus.valE = '0; bus.valM = '0; bus.wb_en = 1'b0; bus.stat_halt = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state: RET reads %rsp on both ports, OP rA=0 reads %rax.
    applyStimulus(4'h9, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    check("reset.rsp", bus.valA, 64'd1024);
    check("reset.halted", 64'(bus.halted), 64'd0);
    applyStimulus(4'h6, 4'h0, 4'h0, 1'b0, 64'h0, 64'h0);
    check("reset.rax", bus.valA, 64'h0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].icode, vecs[i].rA, vecs[i].rB, vecs[i].cnd, vecs[i].valE, vecs[i].valM);
      checkOutput(i, vecs[i]);
      commit(vecs[i].wbEn, 1'b0);
    end

    // Halting commit still writes %rcx, then blocks further writes.
    applyStimulus(4'h3, 4'hF, 4'h1, 1'b0, 64'd9, 64'h0);
    commit(1'b1, 1'b1);
    check("halt.set", 64'(bus.halted), 64'd1);
    applyStimulus(4'h3, 4'hF, 4'h1, 1'b0, 64'd3, 64'h0);
    commit(1'b1, 1'b0);
    applyStimulus(4'h6, 4'h1, 4'h1, 1'b0, 64'h0, 64'h0);
    check("halt.rcx", bus.valA, 64'd9);
    check("halt.sticky", 64'(bus.halted), 64'd1);

    // Reset asserted across a commit edge: write lost, state cleared at once.
    applyStimulus(4'h3, 4'hF, 4'h1, 1'b0, 64'd5, 64'h0);
    bus.wb_en = 1'b1;
    rst = 1'b1;
    #1;
    check("rst.async_halted", 64'(bus.halted), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(4'h6, 4'h1, 4'h4, 1'b0, 64'h0, 64'h0);
    check("rst.rcx", bus.valA, 64'h0);
    check("rst.rsp", bus.valB, 64'd1024);

    // Same-cycle read of a register being written.
    applyStimulus(4'h6, 4'h5, 4'h5, 1'b0, 64'hAB, 64'h0);
    bus.wb_en = 1'b1;
    #1;
`ifdef WB_BYPASS_EN
    check("rdw.valA", bus.valA, 64'hAB);
    check("rdw.valB", bus.valB, 64'hAB);
`else
    check("rdw.valA", bus.valA, 64'h0);
    check("rdw.valB", bus.valB, 64'h0);
`endif
    commit(1'b1, 1'b0);
    applyStimulus(4'h6, 4'h5, 4'h0, 1'b0, 64'h0, 64'h0);
    check("rdw.after", bus.valA, 64'hAB);

    // popq %rsp in flight: M data has priority on a write-through read.
    applyStimulus(4'hB, 4'h4, 4'hF, 1'b0, 64'h408, 64'h77);
    bus.wb_en = 1'b1;
    #1;
`ifdef WB_BYPASS_EN
    check("rdw.pop", bus.valA, 64'h77);
`else
    check("rdw.pop", bus.valA, 64'd1024);
`endif
    commit(1'b1, 1'b0);
    applyStimulus(4'h9, 4'hF, 4'hF, 1'b0, 64'h0, 64'h0);
    check("pop.rsp", bus.valA, 64'h77);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
